// File: rtl/injection_request_issuer.sv
// Wraps address-generator output into valid/ready request beats with patterned write data,
// stepping the generator once per accepted beat that is followed by another beat.
module injection_request_issuer #(
    parameter int WIDTH       = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [COUNT_WIDTH-1:0] transaction_count,
    input  logic                   write_mode,
    input  logic [DATA_WIDTH-1:0]  data_seed,
    input  logic [DATA_WIDTH-1:0]  data_increment,
    input  logic [WIDTH-1:0]       address_in,
    output logic                   address_advance,
    output logic                   request_valid,
    input  logic                   request_ready,
    output logic [WIDTH-1:0]       request_address,
    output logic                   request_write,
    output logic [DATA_WIDTH-1:0]  request_data,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] issued_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    logic [1:0]             state_q,     state_d;
    logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
    logic [COUNT_WIDTH-1:0] issued_q,    issued_d;
    logic                   write_q,     write_d;
    logic [DATA_WIDTH-1:0]  data_q,      data_d;
    logic [DATA_WIDTH-1:0]  inc_q,       inc_d;
    logic [WIDTH-1:0]       req_addr_q,  req_addr_d;
    logic [DATA_WIDTH-1:0]  req_data_q,  req_data_d;
    logic                   req_write_q, req_write_d;
    logic                   valid_q,     valid_d;
    logic                   busy_q,      busy_d;
    logic                   done_q,      done_d;

    logic handshake_s;
    logic last_beat_s;

    assign handshake_s = valid_q & request_ready;
    assign last_beat_s = (remaining_q == CNT_ONE);

    // The generator only steps when another beat will follow, so LOAD sees the next address.
    assign address_advance = handshake_s & ~last_beat_s & ~abort;

    assign request_valid   = valid_q;
    assign request_address = req_addr_q;
    assign request_write   = req_write_q;
    assign request_data    = req_data_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign issued_count    = issued_q;

    // Next-state and run bookkeeping for the IDLE/LOAD/ISSUE/DONE sequence.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        issued_d    = issued_q;
        write_d     = write_q;
        data_d      = data_q;
        inc_d       = inc_q;
        req_addr_d  = req_addr_q;
        req_data_d  = req_data_q;
        req_write_d = req_write_q;
        valid_d     = valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    write_d     = write_mode;
                    data_d      = data_seed;
                    inc_d       = data_increment;
                    issued_d    = '0;
                    remaining_d = transaction_count;
                    busy_d      = 1'b1;
                    if (transaction_count == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                req_addr_d  = address_in;
                req_write_d = write_q;
                if (write_q) begin
                    req_data_d = data_q;
                end else begin
                    req_data_d = '0;
                end
                if (abort) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_ISSUE;
                    valid_d = 1'b1;
                end
            end
            ST_ISSUE: begin
                // Abort is only honoured at the handshake so a presented beat is never withdrawn.
                if (handshake_s) begin
                    issued_d    = issued_q + CNT_ONE;
                    remaining_d = remaining_q - CNT_ONE;
                    data_d      = data_q + inc_q;
                    valid_d     = 1'b0;
                    if (last_beat_s || abort) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            issued_q    <= '0;
            write_q     <= 1'b0;
            data_q      <= '0;
            inc_q       <= '0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            req_write_q <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            issued_q    <= issued_d;
            write_q     <= write_d;
            data_q      <= data_d;
            inc_q       <= inc_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            req_write_q <= req_write_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_injection_request_issuer.sv
// Scoreboard bench for injection_request_issuer: stimulus pushes expected beats and run
// results, an independent negedge monitor pops and compares them.
module tb_injection_request_issuer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] transaction_count = 16'd0;
    logic        write_mode = 1'b0;
    logic [31:0] data_seed = 32'd0;
    logic [31:0] data_increment = 32'd0;
    logic [31:0] address_in;
    logic        address_advance;
    logic        request_valid;
    logic        request_ready = 1'b1;
    logic [31:0] request_address;
    logic        request_write;
    logic [31:0] request_data;
    logic        busy;
    logic        done;
    logic [15:0] issued_count;

    injection_request_issuer dut (
        .clock(clk), .reset(reset), .start(start), .abort(abort),
        .transaction_count(transaction_count), .write_mode(write_mode),
        .data_seed(data_seed), .data_increment(data_increment),
        .address_in(address_in), .address_advance(address_advance),
        .request_valid(request_valid), .request_ready(request_ready),
        .request_address(request_address), .request_write(request_write),
        .request_data(request_data), .busy(busy), .done(done),
        .issued_count(issued_count)
    );

    always #5 clk = ~clk;

    // Address generator model: reloads on gen_load, steps +4 on each advance.
    logic        gen_load = 1'b0;
    logic [31:0] gen_base = 32'd0;
    logic [31:0] gen_addr = 32'd0;
    always @(posedge clk) begin
        if (gen_load) gen_addr <= gen_base;
        else if (address_advance) gen_addr <= gen_addr + 32'd4;
    end
    assign address_in = gen_addr;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          wr;
        bit          last;
        int          cyc;
    } beat_t;

    typedef struct {
        int issued;
        int pulses;
        int cyc;
        bit aborted;
    } run_t;

    beat_t beat_q[$];
    run_t  run_q[$];

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected beats follow directly from the run parameters.
    task automatic expect_run(int count, bit wr, logic [31:0] seed, logic [31:0] inc,
                              logic [31:0] base, int t, bit timed, int exp_issued,
                              bit aborted);
        beat_t b;
        run_t  r;
        for (int i = 0; i < count; i++) begin
            logic [31:0] ii;
            ii     = i;
            b.addr = base + 32'd4 * ii;
            b.data = wr ? (seed + inc * ii) : 32'd0;
            b.wr   = wr;
            b.last = (i == count - 1);
            b.cyc  = timed ? (t + 2 + 2 * i) : -1;
            beat_q.push_back(b);
        end
        r.issued  = exp_issued;
        r.pulses  = (exp_issued == 0) ? 0 : exp_issued - 1;
        r.cyc     = (count == 0) ? t + 1 : (timed ? t + 2 * count + 1 : -1);
        r.aborted = aborted;
        run_q.push_back(r);
    endtask

    // Monitor: compares presented beats, advance pulses and run results against the queues.
    int pulses = 0;
    bit stalled = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            beat_q.delete();
            run_q.delete();
            pulses  = 0;
            stalled = 1'b0;
        end else begin
            if (address_advance) begin
                pulses++;
                check("advance_only_on_handshake", {63'd0, request_valid & request_ready}, 64'd1);
            end
            if (stalled) check("valid_held", {63'd0, request_valid}, 64'd1);
            if (request_valid) begin
                if (beat_q.size() == 0) begin
                    check("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    beat_t e;
                    e = beat_q[0];
                    check("req_address", {32'd0, request_address}, {32'd0, e.addr});
                    check("req_data", {32'd0, request_data}, {32'd0, e.data});
                    check("req_write", {63'd0, request_write}, {63'd0, e.wr});
                    if (!stalled && e.cyc >= 0) check("beat_cycle", 64'(cyc), 64'(e.cyc));
                    if (request_ready) begin
                        check("advance_at_handshake", {63'd0, address_advance},
                              {63'd0, ~e.last & ~abort});
                        void'(beat_q.pop_front());
                    end
                end
            end
            stalled = request_valid & ~request_ready;
            if (done) begin
                if (run_q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    run_t r;
                    r = run_q.pop_front();
                    check("issued_count", {48'd0, issued_count}, 64'(r.issued));
                    check("advance_pulses", 64'(pulses), 64'(r.pulses));
                    check("busy_at_done", {63'd0, busy}, 64'd1);
                    check("valid_at_done", {63'd0, request_valid}, 64'd0);
                    if (r.cyc >= 0) check("done_cycle", 64'(cyc), 64'(r.cyc));
                    if (!r.aborted) check("beats_left", 64'(beat_q.size()), 64'd0);
                end
                beat_q.delete();
                pulses = 0;
            end
        end
    end

    // mode: 0 ready high (timed), 1 random ready, 2 stall beat 2 for 5 cycles, 3 abort on beat 3.
    task automatic run(int count, bit wr, logic [31:0] seed, logic [31:0] inc,
                       logic [31:0] base, int mode, int extra_start_at);
        int  exp_issued;
        int  bi;
        int  hold;
        bit  seen;
        exp_issued = (mode == 3) ? 3 : count;
        bi   = 0;
        hold = 5;
        seen = 1'b0;
        @(posedge clk); #1;
        gen_base          = base;
        gen_load          = 1'b1;
        transaction_count = 16'(count);
        write_mode        = wr;
        data_seed         = seed;
        data_increment    = inc;
        request_ready     = 1'b1;
        abort             = 1'b0;
        expect_run(count, wr, seed, inc, base, cyc, (mode == 0), exp_issued, (mode == 3));
        start = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            start    = (k == extra_start_at);
            gen_load = 1'b0;
            if (done) begin
                seen = 1'b1;
                break;
            end
            case (mode)
                1: request_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (request_valid && bi == 1 && hold > 0) begin
                        request_ready = 1'b0;
                        hold--;
                    end else request_ready = 1'b1;
                end
                3: begin
                    if (request_valid && bi == 2 && hold > 0) begin
                        request_ready = 1'b0;
                        abort = 1'b1;
                        hold--;
                    end else request_ready = 1'b1;
                end
                default: request_ready = 1'b1;
            endcase
            if (request_ready && request_valid) bi++;
        end
        start = 1'b0;
        if (!seen) check("run_timeout", 64'd1, 64'd0);
        abort = 1'b0;
        request_ready = 1'b1;
        @(posedge clk); #1;
        check("busy_after_done", {63'd0, busy}, 64'd0);
        check("done_one_cycle", {63'd0, done}, 64'd0);
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_valid"}, {63'd0, request_valid}, 64'd0);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_done"}, {63'd0, done}, 64'd0);
        check({tag, "_issued"}, {48'd0, issued_count}, 64'd0);
        check({tag, "_addr"}, {32'd0, request_address}, 64'd0);
        check({tag, "_data"}, {32'd0, request_data}, 64'd0);
        check({tag, "_write"}, {63'd0, request_write}, 64'd0);
        check({tag, "_advance"}, {63'd0, address_advance}, 64'd0);
    endtask

    initial begin
        bit got_valid;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        run(4, 1'b1, 32'h10, 32'h1, 32'h100, 0, -1);
        run(3, 1'b1, 32'hA5A5_0000, 32'h0101_0101, 32'h2000, 2, -1);
        run(0, 1'b1, 32'h55, 32'h1, 32'h300, 0, -1);
        run(8, 1'b1, 32'h1000, 32'h10, 32'h400, 3, -1);
        run(4, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h500, 0, -1);

        // Reset while a beat is stalled in ISSUE.
        @(posedge clk); #1;
        gen_base = 32'h600; gen_load = 1'b1;
        transaction_count = 16'd5; write_mode = 1'b1;
        data_seed = 32'h77; data_increment = 32'h3;
        request_ready = 1'b0;
        expect_run(5, 1'b1, 32'h77, 32'h3, 32'h600, cyc, 1'b0, 5, 1'b0);
        start = 1'b1;
        got_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            start = 1'b0; gen_load = 1'b0;
            if (request_valid) begin
                got_valid = 1'b1;
                break;
            end
        end
        check("reset_test_valid_seen", {63'd0, got_valid}, 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check_all_zero("midrun_reset");
        reset = 1'b0;
        request_ready = 1'b1;
        run(4, 1'b1, 32'h9000, 32'h2, 32'h700, 0, 3);

        for (int n = 0; n < 20; n++) begin
            run($urandom_range(0, 6), 1'($urandom_range(0, 1)), $urandom, $urandom,
                $urandom & 32'hFFFF_FFFC, (n % 3 == 0) ? 0 : 1, -1);
        end

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
